branch_resolver: RTL and testbench

- Execute-stage consumer of the branch comparator flags (equal, less-signed, less-unsigned).
- Decodes funct3 and jump type, then decides taken or not-taken and the actual next PC.
- Checks the decision against the fetch-stage prediction and issues a one-shot redirect on a mispredict.
- Registered pipeline stage with valid/ready handshake; an epoch bit squashes wrong-path instructions after a redirect.

---
 rtl/branch_resolver.sv | 135 +++++++++++++
 tb/tb_branch_resolver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: decodes the branch condition, checks the fetch prediction,
// registers the result and issues a one-shot redirect. Optional statistics: RV_BRANCH_STATS_EN.
module branch_resolver #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_epoch,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_isBranch,
  input  logic                  i_isJump,
  input  logic [2:0]            i_funct3,
  input  logic                  i_isEqual,
  input  logic                  i_isLessSigned,
  input  logic                  i_isLessUnsigned,
  input  logic [ADDR_WIDTH-1:0] i_target,
  input  logic                  i_predTaken,
  input  logic [ADDR_WIDTH-1:0] i_predTarget,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_taken,
  output logic [ADDR_WIDTH-1:0] o_linkPc,
  output logic                  o_illegal,
  output logic                  o_redirect,
  output logic [ADDR_WIDTH-1:0] o_redirectPc,
  output logic [CNT_WIDTH-1:0]  o_branchCount,
  output logic [CNT_WIDTH-1:0]  o_mispredictCount
);

  typedef enum logic [2:0] {
    COND_EQ   = 3'b000,
    COND_NE   = 3'b001,
    COND_RSV2 = 3'b010,
    COND_RSV3 = 3'b011,
    COND_LT   = 3'b100,
    COND_GE   = 3'b101,
    COND_LTU  = 3'b110,
    COND_GEU  = 3'b111
  } branchCond_e;

  logic                  epochQ;
  logic                  condTrue;
  logic                  condIllegal;
  logic                  taken;
  logic                  illegal;
  logic                  mispredict;
  logic                  inEpoch;
  logic                  loadEn;
  logic [ADDR_WIDTH-1:0] seqPc;
  logic [ADDR_WIDTH-1:0] nextPc;

  always_comb begin
    condTrue    = 1'b0;
    condIllegal = 1'b0;
    unique case (branchCond_e'(i_funct3))
      COND_EQ:   condTrue = i_isEqual;
      COND_NE:   condTrue = !i_isEqual;
      COND_LT:   condTrue = i_isLessSigned;
      COND_GE:   condTrue = !i_isLessSigned;
      COND_LTU:  condTrue = i_isLessUnsigned;
      COND_GEU:  condTrue = !i_isLessUnsigned;
      COND_RSV2,
      COND_RSV3: condIllegal = 1'b1;
      default:   condIllegal = 1'b1;
    endcase
  end

  // A jump overrides any condition decode, including a reserved funct3.
  assign taken      = i_isJump || (i_isBranch && condTrue);
  assign illegal    = !i_isJump && i_isBranch && condIllegal;
  assign seqPc      = i_pc + ADDR_WIDTH'(4);
  assign nextPc     = taken ? i_target : seqPc;
  assign mispredict = (i_predTaken != taken) || (taken && (i_predTarget != i_target));

  assign o_ready = !o_valid || i_ready;
  assign inEpoch = (i_epoch == epochQ);
  assign loadEn  = i_valid && o_ready && inEpoch && !i_flush;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_valid      <= 1'b0;
      o_redirect   <= 1'b0;
      o_taken      <= 1'b0;
      o_illegal    <= 1'b0;
      o_pc         <= '0;
      o_linkPc     <= '0;
      o_redirectPc <= '0;
      epochQ       <= 1'b0;
    end else begin
      // Redirect is a pulse: only a fresh load can raise it, so a stall never repeats it.
      o_redirect <= 1'b0;
      if (i_flush) begin
        o_valid <= 1'b0;
      end else if (o_ready) begin
        o_valid <= loadEn;
      end
      if (loadEn) begin
        o_pc         <= i_pc;
        o_taken      <= taken;
        o_illegal    <= illegal;
        o_linkPc     <= seqPc;
        o_redirectPc <= nextPc;
        o_redirect   <= mispredict;
        if (mispredict) begin
          epochQ <= !epochQ;
        end
      end
    end
  end

`ifdef RV_BRANCH_STATS_EN
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_branchCount     <= '0;
      o_mispredictCount <= '0;
    end else begin
      if (loadEn && (i_isBranch || i_isJump) && (o_branchCount != '1)) begin
        o_branchCount <= o_branchCount + CNT_WIDTH'(1);
      end
      if (loadEn && mispredict && (o_mispredictCount != '1)) begin
        o_mispredictCount <= o_mispredictCount + CNT_WIDTH'(1);
      end
    end
  end
`else
  assign o_branchCount     = '0;
  assign o_mispredictCount = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver; a second instance with CNT_WIDTH=2
// shares the stimulus to exercise counter saturation.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid, outReady, epoch;
  logic [31:0] pc, target, predTarget;
  logic        isBranch, isJump;
  logic [2:0]  funct3;
  logic        isEqual, isLessSigned, isLessUnsigned, predTaken, flush;
  logic        outValid, downReady;
  logic [31:0] outPc, linkPc, redirectPc;
  logic        taken, illegal, redirect;
  logic [31:0] branchCount, mispredictCount;

  logic        sReady, sValid, sTaken, sIllegal, sRedirect;
  logic [31:0] sPc, sLinkPc, sRedirectPc;
  logic [1:0]  sBranchCount, sMispredictCount;

  int compared   = 0;
  int mismatched = 0;
  int expBr1, expMis1, expBr2, expMis2, expSBr, expSMis;

  always #5 clk = ~clk;

  branch_resolver #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
    .i_clock(clk), .i_reset(rstN), .i_valid(inValid), .o_ready(outReady), .i_epoch(epoch),
    .i_pc(pc), .i_isBranch(isBranch), .i_isJump(isJump), .i_funct3(funct3),
    .i_isEqual(isEqual), .i_isLessSigned(isLessSigned), .i_isLessUnsigned(isLessUnsigned),
    .i_target(target), .i_predTaken(predTaken), .i_predTarget(predTarget), .i_flush(flush),
    .o_valid(outValid), .i_ready(downReady), .o_pc(outPc), .o_taken(taken), .o_linkPc(linkPc),
    .o_illegal(illegal), .o_redirect(redirect), .o_redirectPc(redirectPc),
    .o_branchCount(branchCount), .o_mispredictCount(mispredictCount)
  );

  branch_resolver #(.ADDR_WIDTH(32), .CNT_WIDTH(2)) dutSmall (
    .i_clock(clk), .i_reset(rstN), .i_valid(inValid), .o_ready(sReady), .i_epoch(epoch),
    .i_pc(pc), .i_isBranch(isBranch), .i_isJump(isJump), .i_funct3(funct3),
    .i_isEqual(isEqual), .i_isLessSigned(isLessSigned), .i_isLessUnsigned(isLessUnsigned),
    .i_target(target), .i_predTaken(predTaken), .i_predTarget(predTarget), .i_flush(flush),
    .o_valid(sValid), .i_ready(downReady), .o_pc(sPc), .o_taken(sTaken), .o_linkPc(sLinkPc),
    .o_illegal(sIllegal), .o_redirect(sRedirect), .o_redirectPc(sRedirectPc),
    .o_branchCount(sBranchCount), .o_mispredictCount(sMispredictCount)
  );

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ep, input logic [31:0] p,
                       input logic br, input logic jp, input logic [2:0] f3,
                       input logic eq, input logic lts, input logic ltu,
                       input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    inValid = v; epoch = ep; pc = p; isBranch = br; isJump = jp; funct3 = f3;
    isEqual = eq; isLessSigned = lts; isLessUnsigned = ltu;
    target = tgt; predTaken = pt; predTarget = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic checkOut(input string tag, input logic v, input logic tk, input logic [31:0] p,
                          input logic [31:0] link, input logic ill, input logic rd,
                          input logic [31:0] rdpc);
    checkEq({tag, ".valid"}, 64'(outValid), 64'(v));
    checkEq({tag, ".taken"}, 64'(taken), 64'(tk));
    checkEq({tag, ".pc"}, 64'(outPc), 64'(p));
    checkEq({tag, ".linkPc"}, 64'(linkPc), 64'(link));
    checkEq({tag, ".illegal"}, 64'(illegal), 64'(ill));
    checkEq({tag, ".redirect"}, 64'(redirect), 64'(rd));
    if (rd) checkEq({tag, ".redirectPc"}, 64'(redirectPc), 64'(rdpc));
  endtask

  task automatic checkCounts(input string tag, input int br, input int mis,
                             input int sbr, input int smis);
    checkEq({tag, ".branchCount"}, 64'(branchCount), 64'(br));
    checkEq({tag, ".mispredictCount"}, 64'(mispredictCount), 64'(mis));
    checkEq({tag, ".smallBranchCount"}, 64'(sBranchCount), 64'(sbr));
    checkEq({tag, ".smallMispredictCount"}, 64'(sMispredictCount), 64'(smis));
  endtask

  initial begin
`ifdef RV_BRANCH_STATS_EN
    expBr1 = 2; expMis1 = 2; expBr2 = 9; expMis2 = 6; expSBr = 3; expSMis = 3;
`else
    expBr1 = 0; expMis1 = 0; expBr2 = 0; expMis2 = 0; expSBr = 0; expSMis = 0;
`endif
    rstN = 1'b0; flush = 1'b0; downReady = 1'b1;
    idle();
    #2;
    checkOut("reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    checkEq("reset.redirectPc", 64'(redirectPc), 64'h0);
    checkEq("reset.ready", 64'(outReady), 64'h1);
    checkCounts("reset", 0, 0, 0, 0);
    #10 rstN = 1'b1;

    // BEQ taken, predicted not-taken: redirect to target, epoch 0 -> 1
    drive(1, 0, 32'h100, 1, 0, 3'b000, 1, 0, 0, 32'h140, 0, 32'h0);
    cyc();
    checkOut("beq", 1, 1, 32'h100, 32'h104, 0, 1, 32'h140);

    // BLTU not taken, predicted taken: redirect to pc+4, epoch 1 -> 0
    drive(1, 1, 32'h200, 1, 0, 3'b110, 0, 0, 0, 32'h300, 1, 32'h80);
    cyc();
    checkOut("bltu", 1, 0, 32'h200, 32'h204, 0, 1, 32'h204);

    // Accepted alongside the redirect with the stale epoch: squashed
    drive(1, 1, 32'h300, 0, 0, 3'b000, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc();
    checkEq("squash.valid", 64'(outValid), 64'h0);
    checkEq("squash.redirect", 64'(redirect), 64'h0);
    checkCounts("mid", expBr1, expMis1, expBr1, expMis1);

    drive(1, 0, 32'h400, 0, 0, 3'b000, 0, 0, 0, 32'h0, 0, 32'h0);
    cyc();
    checkOut("newEpoch", 1, 0, 32'h400, 32'h404, 0, 0, 32'h0);

    // JAL correctly predicted; reserved funct3 must be ignored for jumps
    drive(1, 0, 32'h1000, 0, 1, 3'b010, 0, 0, 0, 32'h2000, 1, 32'h2000);
    cyc();
    checkOut("jal", 1, 1, 32'h1000, 32'h1004, 0, 0, 32'h0);

    // JALR with wrong predicted target: epoch 0 -> 1
    drive(1, 0, 32'h1010, 0, 1, 3'b000, 0, 0, 0, 32'h2400, 1, 32'h3000);
    cyc();
    checkOut("jalrTgt", 1, 1, 32'h1010, 32'h1014, 0, 1, 32'h2400);

    // BNE taken, predicted not-taken, then stalled 3 cycles: epoch 1 -> 0
    drive(1, 1, 32'h500, 1, 0, 3'b001, 0, 0, 0, 32'h600, 0, 32'h0);
    cyc();
    checkOut("bne", 1, 1, 32'h500, 32'h504, 0, 1, 32'h600);
    downReady = 1'b0;
    drive(1, 0, 32'h555, 1, 0, 3'b000, 1, 0, 0, 32'h777, 0, 32'h0);
    #1 checkEq("stall.ready", 64'(outReady), 64'h0);
    for (int unsigned i = 0; i < 3; i++) begin
      cyc();
      checkOut("stall", 1, 1, 32'h500, 32'h504, 0, 0, 32'h0);
      checkEq("stall.redirectPc", 64'(redirectPc), 64'h600);
      checkEq("stall.ready", 64'(outReady), 64'h0);
    end
    downReady = 1'b1;
    idle();
    #1 checkEq("drain.ready", 64'(outReady), 64'h1);
    cyc();
    checkEq("drain.valid", 64'(outValid), 64'h0);

    // BLT taken, correctly predicted
    drive(1, 0, 32'h900, 1, 0, 3'b100, 0, 1, 0, 32'h880, 1, 32'h880);
    cyc();
    checkOut("blt", 1, 1, 32'h900, 32'h904, 0, 0, 32'h0);

    // BGE not taken (lessS), correctly predicted
    drive(1, 0, 32'h910, 1, 0, 3'b101, 0, 1, 0, 32'h990, 0, 32'h0);
    cyc();
    checkOut("bge", 1, 0, 32'h910, 32'h914, 0, 0, 32'h0);

    // BGEU taken, predicted not-taken: epoch 0 -> 1
    drive(1, 0, 32'hA00, 1, 0, 3'b111, 0, 1, 0, 32'hA40, 0, 32'h0);
    cyc();
    checkOut("bgeu", 1, 1, 32'hA00, 32'hA04, 0, 1, 32'hA40);

    // Reserved funct3 on a branch: illegal, not taken
    drive(1, 1, 32'h700, 1, 0, 3'b010, 1, 1, 1, 32'h800, 0, 32'h0);
    cyc();
    checkOut("illegal", 1, 0, 32'h700, 32'h704, 1, 0, 32'h0);

    // Flush beats a mispredicting accept; epoch stays 1
    flush = 1'b1;
    drive(1, 1, 32'hB00, 1, 0, 3'b000, 1, 0, 0, 32'hB80, 0, 32'h0);
    cyc();
    flush = 1'b0;
    checkEq("flush.valid", 64'(outValid), 64'h0);
    checkEq("flush.redirect", 64'(redirect), 64'h0);

    // Non-control predicted taken at top of address space: redirect to wrapped pc+4
    drive(1, 1, 32'hFFFF_FFFC, 0, 0, 3'b000, 0, 0, 0, 32'h0, 1, 32'h10);
    cyc();
    checkOut("wrap", 1, 0, 32'hFFFF_FFFC, 32'h0, 0, 1, 32'h0);

    idle();
    cyc();
    checkEq("idle.valid", 64'(outValid), 64'h0);
    checkEq("idle.redirect", 64'(redirect), 64'h0);
    checkCounts("end", expBr2, expMis2, expSBr, expSMis);

    // Async reset while an entry is stalled: drops it immediately
    drive(1, 0, 32'h1234, 1, 0, 3'b000, 1, 0, 0, 32'h1300, 1, 32'h1300);
    cyc();
    checkEq("preReset.valid", 64'(outValid), 64'h1);
    downReady = 1'b0;
    idle();
    #2 rstN = 1'b0;
    #1;
    checkOut("asyncReset", 0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkEq("asyncReset.redirectPc", 64'(redirectPc), 64'h0);
    checkCounts("asyncReset", 0, 0, 0, 0);
    #3 rstN = 1'b1;
    downReady = 1'b1;
    cyc();
    checkEq("postReset.valid", 64'(outValid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
